fetch_pc_unit: RTL and testbench

- Program-counter and fetch-control stage directly upstream of the instruction ROM.
- Drives the ROM word address and holds it frozen on pipeline hazards.
- Redirects the address on taken branches and stops at the end of the program image.
- Tracks which PC produced the word currently on the ROM output, and flags whether that word is valid, for the IF/ID register downstream.

---
 rtl/fetch_pc_unit_if.sv | 25 ++
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus between the PC unit and its environment: control inputs
// from execute/hazard logic, ROM address and IF/ID status outputs.
interface fetch_pc_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              hazard;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] mem_address;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic              halted;
  logic [15:0]       fetch_count;
  logic [15:0]       stall_count;

  modport master (
    output hazard, branch_taken, branch_target,
    input  mem_address, fetch_pc, fetch_valid, halted, fetch_count, stall_count
  );

  modport slave (
    input  hazard, branch_taken, branch_target,
    output mem_address, fetch_pc, fetch_valid, halted, fetch_count, stall_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter / fetch control in front of the instruction ROM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}}
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.slave fetch_if
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              halted_q, halted_d;

  // Next-state logic; priority is branch, then hazard, then normal advance.
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    if (fetch_if.branch_taken) begin
      // ROM still latches a word on this edge; it is wrong-path, so squash it.
      mem_address_d = fetch_if.branch_target;
      fetch_pc_d    = mem_address_q;
      fetch_valid_d = 1'b0;
      state_d       = ST_RUN;
      halted_d      = 1'b0;
    end else if (fetch_if.hazard) begin
      state_d = state_q;
    end else begin
      fetch_pc_d = mem_address_q;
      case (state_q)
        ST_RUN: begin
          fetch_valid_d = 1'b1;
          if (mem_address_q == PC_LAST) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            mem_address_d = mem_address_q + ADDR_W'(1);
          end
        end
        ST_HALT: begin
          fetch_valid_d = 1'b0;
          halted_d      = 1'b1;
        end
        default: begin
          state_d       = ST_RUN;
          mem_address_d = RESET_PC;
          fetch_valid_d = 1'b0;
          halted_d      = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      mem_address_q <= RESET_PC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign fetch_if.mem_address = mem_address_q;
  assign fetch_if.fetch_pc    = fetch_pc_q;
  assign fetch_if.fetch_valid = fetch_valid_q;
  assign fetch_if.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_evt_s, stall_evt_s;
  logic [15:0] fetch_count_q, stall_count_q;

  assign fetch_evt_s = !fetch_if.branch_taken && !fetch_if.hazard && (state_q == ST_RUN);
  assign stall_evt_s = !fetch_if.branch_taken &&  fetch_if.hazard && (state_q == ST_RUN);

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      if (fetch_evt_s && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (stall_evt_s && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign fetch_if.fetch_count = fetch_count_q;
  assign fetch_if.stall_count = stall_count_q;
`else
  assign fetch_if.fetch_count = 16'd0;
  assign fetch_if.stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: each scenario queues the expected
// post-edge outputs, drives one cycle, then pops and compares.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [7:0] mem;
    logic [7:0] fpc;
    logic       valid;
    logic       halted;
  } obs_t;

  typedef struct {
    logic       hz;
    logic       br;
    logic [7:0] tgt;
    obs_t       e;
    bit         fetched;
    bit         stalled;
  } step_t;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests    = 0;
  int   failures = 0;
  int   exp_fetch = 0;
  int   exp_stall = 0;
  obs_t sb[$];

  fetch_pc_unit_if #(.ADDR_W(8)) bus_if ();

  fetch_pc_unit #(
    .ADDR_W  (8),
    .RESET_PC(8'd0),
    .PC_LAST (8'd255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fetch_if(bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic hz, input logic br, input logic [7:0] tgt,
                               input logic [7:0] mem, input logic [7:0] fpc,
                               input logic v, input logic h, input bit f, input bit s);
    step_t st;
    st.hz = hz; st.br = br; st.tgt = tgt;
    st.e.mem = mem; st.e.fpc = fpc; st.e.valid = v; st.e.halted = h;
    st.fetched = f; st.stalled = s;
    return st;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.mem = bus_if.mem_address; o.fpc = bus_if.fetch_pc;
    o.valid = bus_if.fetch_valid; o.halted = bus_if.halted;
    return o;
  endfunction

  task automatic drive(input logic hz, input logic br, input logic [7:0] tgt);
    bus_if.hazard = hz; bus_if.branch_taken = br; bus_if.branch_target = tgt;
    @(posedge clk);
    #1;
    bus_if.hazard = 1'b0; bus_if.branch_taken = 1'b0; bus_if.branch_target = 8'd0;
  endtask

  task automatic test_reset();
    obs_t got;
    bus_if.hazard = 1'b0; bus_if.branch_taken = 1'b0; bus_if.branch_target = 8'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    tests++;
    if (got !== 18'd0) begin
      failures++;
      $display("FAIL reset_state: got mem=%0h fpc=%0h v=%0b h=%0b, expected all 0",
               got.mem, got.fpc, got.valid, got.halted);
    end
    tests++;
    if (bus_if.fetch_count !== 16'd0 || bus_if.stall_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got fc=%0d sc=%0d, expected 0/0",
               bus_if.fetch_count, bus_if.stall_count);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    step_t st[$];
    obs_t  got, e;
    for (int k = 1; k <= 5; k++) st.push_back(mk(0, 0, 8'd0, 8'(k), 8'(k - 1), 1, 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL sequential[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_hazard();
    step_t st[$];
    obs_t  got, e;
    int    exp_sc;
    st.push_back(mk(0, 0, 8'd0, 8'd6, 8'd5, 1, 0, 1, 0));
    repeat (3) st.push_back(mk(1, 0, 8'd0, 8'd6, 8'd5, 1, 0, 0, 1));
    st.push_back(mk(0, 0, 8'd0, 8'd7, 8'd6, 1, 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      if (st[i].stalled) exp_stall++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL hazard[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
    exp_sc = PERF ? 3 : 0;
    tests++;
    if (bus_if.stall_count !== 16'(exp_sc)) begin
      failures++;
      $display("FAIL stall_count: got %0d, expected %0d", bus_if.stall_count, exp_sc);
    end
  endtask

  task automatic test_branch();
    step_t st[$];
    obs_t  got, e;
    st.push_back(mk(0, 0, 8'd0,  8'd8,  8'd7,  1, 0, 1, 0));
    st.push_back(mk(0, 0, 8'd0,  8'd9,  8'd8,  1, 0, 1, 0));
    st.push_back(mk(0, 1, 8'h40, 8'h40, 8'd9,  0, 0, 0, 0));
    st.push_back(mk(0, 0, 8'd0,  8'h41, 8'h40, 1, 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL branch[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_branch_hazard();
    step_t st[$];
    obs_t  got, e;
    int    exp_sc;
    st.push_back(mk(1, 1, 8'h10, 8'h10, 8'h41, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 8'd0,  8'h11, 8'h10, 1, 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL branch_hazard[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
    exp_sc = PERF ? exp_stall : 0;
    tests++;
    if (bus_if.stall_count !== 16'(exp_sc)) begin
      failures++;
      $display("FAIL branch_hazard_stall: got %0d, expected %0d", bus_if.stall_count, exp_sc);
    end
  endtask

  task automatic test_halt();
    step_t st[$];
    obs_t  got, e;
    int    exp_fc, exp_sc;
    st.push_back(mk(0, 1, 8'd250, 8'd250, 8'h11, 0, 0, 0, 0));
    for (int k = 251; k <= 255; k++) st.push_back(mk(0, 0, 8'd0, 8'(k), 8'(k - 1), 1, 0, 1, 0));
    st.push_back(mk(0, 0, 8'd0, 8'd255, 8'd255, 1, 1, 1, 0));
    repeat (3) st.push_back(mk(0, 0, 8'd0, 8'd255, 8'd255, 0, 1, 0, 0));
    st.push_back(mk(1, 0, 8'd0, 8'd255, 8'd255, 0, 1, 0, 0));
    st.push_back(mk(0, 1, 8'd3, 8'd3, 8'd255, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 8'd0, 8'd4, 8'd3, 1, 0, 1, 0));
    st.push_back(mk(0, 1, 8'd255, 8'd255, 8'd4, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 8'd0, 8'd255, 8'd255, 1, 1, 1, 0));
    st.push_back(mk(0, 0, 8'd0, 8'd255, 8'd255, 0, 1, 0, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      if (st[i].stalled) exp_stall++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL halt[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
    exp_fc = PERF ? exp_fetch : 0;
    exp_sc = PERF ? exp_stall : 0;
    tests++;
    if (bus_if.fetch_count !== 16'(exp_fc) || bus_if.stall_count !== 16'(exp_sc)) begin
      failures++;
      $display("FAIL halt_counters: got fc=%0d sc=%0d, expected fc=%0d sc=%0d",
               bus_if.fetch_count, bus_if.stall_count, exp_fc, exp_sc);
    end
  endtask

  task automatic test_mid_reset();
    step_t st[$];
    obs_t  got, e;
    int    exp_fc;
    st.push_back(mk(0, 1, 8'h20, 8'h20, 8'd255, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 8'd0,  8'h21, 8'h20,  1, 0, 1, 0));
    st.push_back(mk(0, 0, 8'd0,  8'h22, 8'h21,  1, 0, 1, 0));
    foreach (st[i]) begin
      sb.push_back(st[i].e);
      if (st[i].fetched) exp_fetch++;
      drive(st[i].hz, st[i].br, st[i].tgt);
      got = observe(); e = sb.pop_front();
      tests++;
      if (got !== e) begin
        failures++;
        $display("FAIL mid_reset_pre[%0d]: got mem=%0h fpc=%0h v=%0b h=%0b, expected mem=%0h fpc=%0h v=%0b h=%0b",
                 i, got.mem, got.fpc, got.valid, got.halted, e.mem, e.fpc, e.valid, e.halted);
      end
    end
    #1;
    rst = 1'b0;
    #1;
    exp_fetch = 0;
    exp_stall = 0;
    got = observe();
    tests++;
    if (got !== 18'd0 || bus_if.fetch_count !== 16'd0 || bus_if.stall_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got mem=%0h fpc=%0h v=%0b h=%0b fc=%0d, expected all 0",
               got.mem, got.fpc, got.valid, got.halted, bus_if.fetch_count);
    end
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(0, 0, 8'd0, 8'd1, 8'd0, 1, 0, 1, 0).e);
    exp_fetch++;
    drive(1'b0, 1'b0, 8'd0);
    got = observe(); e = sb.pop_front();
    tests++;
    if (got !== e) begin
      failures++;
      $display("FAIL mid_reset_restart: got mem=%0h fpc=%0h v=%0b, expected mem=%0h fpc=%0h v=%0b",
               got.mem, got.fpc, got.valid, e.mem, e.fpc, e.valid);
    end
    exp_fc = PERF ? exp_fetch : 0;
    tests++;
    if (bus_if.fetch_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL mid_reset_fetch_count: got %0d, expected %0d", bus_if.fetch_count, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hazard();
    test_branch();
    test_branch_hazard();
    test_halt();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
